ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-select and forwarding logic that feeds the 32-bit ALU in the EX stage.
- Captures decoded ID fields each cycle.
- Detects load-use hazards and inserts bubbles on its own.
- Resolves RAW hazards from the EX/MEM and MEM/WB stages, then drives the ALU operands in1/in2, ALUCtl and Sign.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID slot holds a real instruction.
- id_rs_addr, id_rt_addr, id_rd_addr  in  RW each  source and destination register numbers.
- id_rs_data, id_rt_data  in  DW each  register-file read data.
- id_imm  in  DW  extended immediate.
- id_shamt  in  5  shift amount.
- id_alu_ctl  in  5  ALU opcode, passed through.
- id_sign  in  1  signed compare, passed through.
- id_src1_shamt  in  1  in1 = shamt instead of rs.
- id_src2_imm  in  1  in2 = imm instead of rt.
- id_reg_write  in  1  instruction writes rd.
- id_mem_read  in  1  instruction is a load.
- hold  in  1  downstream stall; freeze the register.
- flush  in  1  branch/jump squash; load a bubble.
- exm_reg_write  in  1  EX/MEM forwarding source valid.
- exm_rd  in  RW  EX/MEM destination register.
- exm_result  in  DW  EX/MEM result.
- wb_reg_write  in  1  MEM/WB forwarding source valid.
- wb_rd  in  RW  MEM/WB destination register.
- wb_result  in  DW  MEM/WB result.
- alu_in1, alu_in2  out  DW each  ALU operands.
- alu_ctl  out  5  ALU opcode.
- alu_sign  out  1  ALU signed compare.
- ex_valid  out  1  EX slot holds a real instruction.
- ex_rd  out  RW  EX destination register.
- ex_reg_write  out  1  gated by ex_valid.
- ex_mem_read  out  1  gated by ex_valid.
- ex_store_data  out  DW  forwarded rt value.
- load_use_stall  out  1  combinational; upstream must hold PC and IF/ID.

Behaviour:
- Reset (clk edge with reset=1): all registered fields cleared to 0.
  - Outputs after reset: ex_valid=0, ex_reg_write=0, ex_mem_read=0, alu_ctl=0 (ALU outputs 0 for AND of zeros), alu_in1=alu_in2=0.
  - Reset overrides hold and flush.
- load_use_stall = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & (ex_rd==id_rs_addr | ex_rd==id_rt_addr).
- Register update priority each edge:
  - reset > flush > hold > load_use_stall > normal.
  - flush or load_use_stall: capture a bubble (valid=0, reg_write=0, mem_read=0, alu_ctl=0, data fields 0).
  - hold: keep all state.
  - Normal: capture all id_* fields.
  - flush with hold at the same time: bubble wins, so a squashed instruction never survives.
- Latency: ID fields appear on EX outputs exactly 1 cycle after capture.
- Forwarding is combinational on the registered rs/rt, applied independently to rs and rt:
  - Use exm_result if exm_reg_write & exm_rd!=0 & exm_rd==addr.
  - Else use wb_result if wb_reg_write & wb_rd!=0 & wb_rd==addr.
  - Else use the registered data.
  - EX/MEM has priority over MEM/WB.
  - Register 0 is never forwarded; it always reads the registered value.
- Operand select:
  - alu_in1 = src1_shamt ? {27'b0, shamt} : fwd_rs.
  - alu_in2 = src2_imm ? imm : fwd_rt.
  - ex_store_data = fwd_rt regardless of src2_imm.
- Shift convention: the ALU uses in1[4:0] as shift amount and in2 as the shifted value. For sll/srl/sra, ID sets src1_shamt=1 and in2=rt; variable shifts (sllv etc.) use rs in in1.
- While ex_valid=0, forwarding still computes, but ex_reg_write=0 guarantees no side effect downstream.
- Forwarding values are re-evaluated every cycle during hold, so a result arriving later in EX/MEM or MEM/WB is picked up.

Optional Feature:
- Macro EX_FORWARD_EN.
  - Defined: forwarding as above.
  - Undefined: fwd_rs/fwd_rt are the registered data only, and the exm_*/wb_* ports are present but ignored.
  - Undefined also widens load_use_stall to any valid EX or EX/MEM writer matching rs/rt (rd!=0), so correctness is kept by stalling.

Test Plan:
- Reset with hold=1, flush=1 -> next cycle ex_valid=0, alu_in1=alu_in2=0, alu_ctl=0, ex_reg_write=0.
- Capture add: rs=$1=5, rt=$2=7, alu_ctl=00010, no forwards -> one cycle later alu_in1=5, alu_in2=7, ex_rd as given, ex_valid=1.
- Forward priority: EX rs=$3; exm_rd=3 with exm_result=0x11; wb_rd=3 with wb_result=0x22 -> alu_in1=0x11. Drop exm_reg_write -> 0x22. Set addr=0 with exm_rd=0 -> registered value.
- Shift: sll with shamt=4, rt=0x1 (src1_shamt=1) -> alu_in1=0x00000004, alu_in2=0x1.
- Load-use: EX holds lw to $8, ID valid with rs=$8 -> load_use_stall=1; next cycle ex_valid=0; the ID instruction, re-presented, captures on the following edge.
- flush and hold asserted together with valid ID -> next cycle ex_valid=0. With hold only -> all outputs unchanged for 3 cycles while exm_result changes are still reflected in alu_in1.

Source files
------------

// File: rtl/ex_operand_stage_if.sv
// ID/EX operand-stage bundle: decoded ID fields, pipeline control, forwarding
// sources and the EX-side outputs that feed the ALU and downstream stages.
interface ex_operand_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          id_valid;
  logic [RW-1:0] id_rs_addr, id_rt_addr, id_rd_addr;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]    id_shamt, id_alu_ctl;
  logic          id_sign, id_src1_shamt, id_src2_imm, id_reg_write, id_mem_read;
  logic          hold, flush;
  logic          exm_reg_write;
  logic [RW-1:0] exm_rd;
  logic [DW-1:0] exm_result;
  logic          wb_reg_write;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_result;
  logic [DW-1:0] alu_in1, alu_in2;
  logic [4:0]    alu_ctl;
  logic          alu_sign;
  logic          ex_valid;
  logic [RW-1:0] ex_rd;
  logic          ex_reg_write, ex_mem_read;
  logic [DW-1:0] ex_store_data;
  logic          load_use_stall;

  modport master (
    output id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data,
           id_imm, id_shamt, id_alu_ctl, id_sign, id_src1_shamt, id_src2_imm,
           id_reg_write, id_mem_read, hold, flush,
           exm_reg_write, exm_rd, exm_result, wb_reg_write, wb_rd, wb_result,
    input  alu_in1, alu_in2, alu_ctl, alu_sign, ex_valid, ex_rd, ex_reg_write,
           ex_mem_read, ex_store_data, load_use_stall
  );

  modport slave (
    input  id_valid, id_rs_addr, id_rt_addr, id_rd_addr, id_rs_data, id_rt_data,
           id_imm, id_shamt, id_alu_ctl, id_sign, id_src1_shamt, id_src2_imm,
           id_reg_write, id_mem_read, hold, flush,
           exm_reg_write, exm_rd, exm_result, wb_reg_write, wb_rd, wb_result,
    output alu_in1, alu_in2, alu_ctl, alu_sign, ex_valid, ex_rd, ex_reg_write,
           ex_mem_read, ex_store_data, load_use_stall
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX register with load-use bubbling, RAW forwarding and ALU operand select.
// Define EX_FORWARD_EN for EX/MEM + MEM/WB bypass; otherwise hazards are stalled.
module ex_operand_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input logic               clk,
  input logic               reset,
  ex_operand_stage_if.slave bus
);
  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rs, rt, rd;
    logic [DW-1:0] rs_data, rt_data, imm;
    logic [4:0]    shamt, alu_ctl;
    logic          sign, src1_shamt, src2_imm, reg_write, mem_read;
  } ex_reg_t;

  ex_reg_t       ex_q, ex_d;
  logic [DW-1:0] fwd_rs, fwd_rt;
  logic          stall;

  // Register 0 is hardwired, so it never counts as a producer match.
  function automatic logic hit(input logic we, input logic [RW-1:0] rd,
                               input logic [RW-1:0] a);
    return we && (rd != '0) && (rd == a);
  endfunction

  always_comb begin
    stall = bus.id_valid && ex_q.valid && ex_q.mem_read &&
            (hit(1'b1, ex_q.rd, bus.id_rs_addr) || hit(1'b1, ex_q.rd, bus.id_rt_addr));
`ifndef EX_FORWARD_EN
    // No bypass paths: any in-flight writer of a source has to drain first.
    if (bus.id_valid &&
        (hit(ex_q.valid && ex_q.reg_write, ex_q.rd, bus.id_rs_addr) ||
         hit(ex_q.valid && ex_q.reg_write, ex_q.rd, bus.id_rt_addr) ||
         hit(bus.exm_reg_write, bus.exm_rd, bus.id_rs_addr) ||
         hit(bus.exm_reg_write, bus.exm_rd, bus.id_rt_addr)))
      stall = 1'b1;
`endif
  end

`ifdef EX_FORWARD_EN
  always_comb begin
    fwd_rs = ex_q.rs_data;
    fwd_rt = ex_q.rt_data;
    if (hit(bus.exm_reg_write, bus.exm_rd, ex_q.rs))     fwd_rs = bus.exm_result;
    else if (hit(bus.wb_reg_write, bus.wb_rd, ex_q.rs))  fwd_rs = bus.wb_result;
    if (hit(bus.exm_reg_write, bus.exm_rd, ex_q.rt))     fwd_rt = bus.exm_result;
    else if (hit(bus.wb_reg_write, bus.wb_rd, ex_q.rt))  fwd_rt = bus.wb_result;
  end
`else
  assign fwd_rs = ex_q.rs_data;
  assign fwd_rt = ex_q.rt_data;
  logic unused_fwd;
  assign unused_fwd = ^{bus.exm_result, bus.wb_reg_write, bus.wb_rd, bus.wb_result,
                        ex_q.rs, ex_q.rt};
`endif

  // flush beats hold so a squashed instruction can never be frozen in EX.
  always_comb begin
    ex_d = ex_q;
    if (bus.flush || (!bus.hold && stall)) begin
      ex_d = '0;
    end else if (!bus.hold) begin
      ex_d.valid      = bus.id_valid;
      ex_d.rs         = bus.id_rs_addr;
      ex_d.rt         = bus.id_rt_addr;
      ex_d.rd         = bus.id_rd_addr;
      ex_d.rs_data    = bus.id_rs_data;
      ex_d.rt_data    = bus.id_rt_data;
      ex_d.imm        = bus.id_imm;
      ex_d.shamt      = bus.id_shamt;
      ex_d.alu_ctl    = bus.id_alu_ctl;
      ex_d.sign       = bus.id_sign;
      ex_d.src1_shamt = bus.id_src1_shamt;
      ex_d.src2_imm   = bus.id_src2_imm;
      ex_d.reg_write  = bus.id_reg_write;
      ex_d.mem_read   = bus.id_mem_read;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  assign bus.alu_in1        = ex_q.src1_shamt ? {{(DW-5){1'b0}}, ex_q.shamt} : fwd_rs;
  assign bus.alu_in2        = ex_q.src2_imm ? ex_q.imm : fwd_rt;
  assign bus.ex_store_data  = fwd_rt;
  assign bus.alu_ctl        = ex_q.alu_ctl;
  assign bus.alu_sign       = ex_q.sign;
  assign bus.ex_valid       = ex_q.valid;
  assign bus.ex_rd          = ex_q.rd;
  assign bus.ex_reg_write   = ex_q.valid & ex_q.reg_write;
  assign bus.ex_mem_read    = ex_q.valid & ex_q.mem_read;
  assign bus.load_use_stall = stall;
endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: stimulus queues hand-computed EX-side
// expectations per cycle, a negedge monitor pops and compares them.
module tb_ex_operand_stage;
`ifdef EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  logic done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ex_operand_stage_if #(.DW(32), .RW(5)) bus ();
  ex_operand_stage #(.DW(32), .RW(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int          cyc;
    logic        v;
    logic [31:0] in1, in2;
    logic [4:0]  ctl;
    logic        sg;
    logic [4:0]  rd;
    logic        rw, mr;
    logic [31:0] st;
    logic        stl;
  } exp_t;
  exp_t q[$];

  task automatic push(input logic v, input logic [31:0] in1, input logic [31:0] in2,
                      input logic [4:0] ctl, input logic sg, input logic [4:0] rd,
                      input logic rw, input logic mr, input logic [31:0] st,
                      input logic stl);
    exp_t e;
    e.cyc = cyc; e.v = v; e.in1 = in1; e.in2 = in2; e.ctl = ctl; e.sg = sg;
    e.rd = rd; e.rw = rw; e.mr = mr; e.st = st; e.stl = stl;
    q.push_back(e);
  endtask

  task automatic id_set(input logic v, input logic [4:0] rs, input logic [31:0] rsd,
                        input logic [4:0] rt, input logic [31:0] rtd, input logic [4:0] rd,
                        input logic [31:0] imm, input logic [4:0] sh, input logic [4:0] ctl,
                        input logic sg, input logic s1, input logic s2, input logic rw,
                        input logic mr);
    bus.id_valid = v; bus.id_rs_addr = rs; bus.id_rs_data = rsd;
    bus.id_rt_addr = rt; bus.id_rt_data = rtd; bus.id_rd_addr = rd;
    bus.id_imm = imm; bus.id_shamt = sh; bus.id_alu_ctl = ctl; bus.id_sign = sg;
    bus.id_src1_shamt = s1; bus.id_src2_imm = s2; bus.id_reg_write = rw;
    bus.id_mem_read = mr;
  endtask

  task automatic id_idle();
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic exm(input logic we, input logic [4:0] rd, input logic [31:0] res);
    bus.exm_reg_write = we; bus.exm_rd = rd; bus.exm_result = res;
  endtask

  task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] res);
    bus.wb_reg_write = we; bus.wb_rd = rd; bus.wb_result = res;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
    end
  endtask

  // Monitor: compares the EX-side outputs against the entry queued for this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      chk("stale_expectation", 32'(cyc), 32'(e.cyc));
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("ex_valid", 32'(bus.ex_valid), 32'(e.v));
      chk("alu_in1", bus.alu_in1, e.in1);
      chk("alu_in2", bus.alu_in2, e.in2);
      chk("alu_ctl", 32'(bus.alu_ctl), 32'(e.ctl));
      chk("alu_sign", 32'(bus.alu_sign), 32'(e.sg));
      chk("ex_rd", 32'(bus.ex_rd), 32'(e.rd));
      chk("ex_reg_write", 32'(bus.ex_reg_write), 32'(e.rw));
      chk("ex_mem_read", 32'(bus.ex_mem_read), 32'(e.mr));
      chk("ex_store_data", bus.ex_store_data, e.st);
      chk("load_use_stall", 32'(bus.load_use_stall), 32'(e.stl));
    end
    if (done) begin
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
    end
  end

  initial begin
    repeat (500) @(posedge clk);
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; bus.hold = 1'b1; bus.flush = 1'b1;
    exm(0, 0, 0); wb(0, 0, 0);
    id_set(1, 1, 32'hDEAD, 2, 32'hBEEF, 9, 32'h1234, 7, 5, 1, 1, 1, 1, 1);
    tick(); // 1: reset captured despite hold/flush
    reset = 1'b0; bus.hold = 1'b0; bus.flush = 1'b0;
    id_set(1, 1, 5, 2, 7, 4, 0, 0, 2, 0, 0, 0, 1, 0);                 // add $4,$1,$2
    push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); // 2
    id_set(1, 0, 0, 5, 1, 6, 0, 4, 3, 1, 1, 0, 1, 0);                 // sll $6,$5,4
    push(1, 5, 7, 2, 0, 4, 1, 0, 7, 0);
    tick(); // 3
    id_set(1, 3, 32'h33, 0, 32'h44, 7, 0, 0, 2, 0, 0, 0, 1, 0);       // rs=$3, rt=$0
    push(1, 4, 1, 3, 1, 6, 1, 0, 1, 0);
    tick(); // 4: hold EX, both stages write $3
    id_idle(); bus.hold = 1'b1;
    exm(1, 3, 32'h11); wb(1, 3, 32'h22);
    push(1, FWD ? 32'h11 : 32'h33, 32'h44, 2, 0, 7, 1, 0, 32'h44, 0);
    tick(); // 5
    bus.exm_reg_write = 1'b0;
    push(1, FWD ? 32'h22 : 32'h33, 32'h44, 2, 0, 7, 1, 0, 32'h44, 0);
    tick(); // 6: writers to $0 must not forward
    exm(1, 0, 32'h55); wb(1, 0, 32'h66);
    push(1, 32'h33, 32'h44, 2, 0, 7, 1, 0, 32'h44, 0);
    tick(); // 7: late EX/MEM result during hold
    exm(1, 3, 32'hA0); wb(0, 0, 0);
    push(1, FWD ? 32'hA0 : 32'h33, 32'h44, 2, 0, 7, 1, 0, 32'h44, 0);
    tick(); // 8
    bus.exm_result = 32'hB0;
    push(1, FWD ? 32'hB0 : 32'h33, 32'h44, 2, 0, 7, 1, 0, 32'h44, 0);
    tick(); // 9
    bus.hold = 1'b0; exm(0, 0, 0);
    id_set(1, 1, 32'h100, 0, 0, 8, 8, 0, 2, 0, 0, 1, 1, 1);           // lw $8,8($1)
    push(1, 32'h33, 32'h44, 2, 0, 7, 1, 0, 32'h44, 0);
    tick(); // 10: dependent add in ID -> stall
    id_set(1, 8, 9, 2, 7, 10, 0, 0, 2, 0, 0, 0, 1, 0);
    push(1, 32'h100, 8, 2, 0, 8, 1, 1, 0, 1);
    tick(); // 11: bubble, add re-presented
    push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); // 12
    bus.hold = 1'b1; bus.flush = 1'b1;
    id_set(1, 1, 1, 2, 2, 11, 0, 0, 1, 0, 0, 0, 1, 0);
    push(1, 9, 7, 2, 0, 10, 1, 0, 7, 0);
    tick(); // 13: flush+hold squashed it
    bus.hold = 1'b0; bus.flush = 1'b0; id_idle();
    push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); // 14: EX/MEM writer matches ID rs
    id_set(1, 12, 32'h12, 0, 0, 13, 3, 0, 2, 0, 0, 1, 1, 0);
    exm(1, 12, 32'h77);
    push(0, 0, 0, 0, 0, 0, 0, 0, 0, FWD ? 1'b0 : 1'b1);
    tick(); // 15
    exm(0, 0, 0);
    id_set(0, 0, 0, 0, 0, 14, 0, 0, 0, 0, 0, 0, 1, 1);
    if (FWD) push(1, 32'h12, 3, 2, 0, 13, 1, 0, 0, 0);
    else     push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); // 16: invalid slot gates reg_write/mem_read
    id_idle();
    push(0, 0, 0, 0, 0, 14, 0, 0, 0, 0);
    tick();
    tick();
    done = 1'b1;
  end
endmodule
